seg7_scan_ctrl: RTL
===================

# seg7_scan_ctrl

Time-multiplexed scan controller for the 4-digit, common-anode seven-segment display. It holds four hex digits plus decimal points and steps a digit index 0..3 at a programmable refresh rate. For each slot it drives the matching active-low anode and the decoded active-low cathodes. New display values arrive over a valid/ready load port and are applied only at frame boundaries, so a displayed frame never tears.

## Interface
- REFRESH_DIV, default 100000: clock cycles each digit is lit per slot; minimum 2.
- BLANK_CYCLES, default 1000: all-anodes-off cycles between slots (used only with SEG7_BLANK_EN); minimum 1.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- load_valid  in  1  load request.
- load_ready  out  1  shadow register free; a load is accepted when load_valid && load_ready.
- load_data  in  16  four hex nibbles; digit0 = [3:0], digit3 = [15:12].
- load_dp  in  4  per-digit decimal point, active-high; bit i = digit i.
- load_en  in  4  per-digit enable mask; 0 = digit dark.
- an  out  4  anodes, active-low; index 0 -> 4'b1110, 1 -> 4'b1101, 2 -> 4'b1011, 3 -> 4'b0111.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point cathode, active-low.
- frame_start  out  1  one-cycle pulse on the first lit cycle of digit 0.

## Operation
- Two register sets:
  - Active set: data, dp, en; drives the display.
  - Shadow set: data, dp, en, plus a pending flag.
- On accept, the load is captured into the shadow set, pending is set, and load_ready drops the next cycle.
- Frame boundary is the cycle in which the index wraps 3 -> 0. If pending is set on that cycle, shadow is copied to active, pending clears, and load_ready rises the following cycle.
- A load accepted on the boundary cycle itself is not applied until the next boundary.
- States:
  - DISPLAY: prescaler counts 0..REFRESH_DIV-1. an = anode code for the index, or 4'b1111 if en[index]=0. seg = hex decode of nibble[index]. dp = ~dp[index]. Disabled digits force seg=7'h7F, dp=1.
  - BLANK: an=4'b1111, seg=7'h7F, dp=1 for BLANK_CYCLES.
- Transitions: DISPLAY at terminal count -> BLANK, or directly to next index's DISPLAY if blanking is compiled out. BLANK at terminal count -> next index's DISPLAY.
- Index wraps 3 -> 0. Prescaler width is $clog2(max(REFRESH_DIV, BLANK_CYCLES)) and resets to 0 on every state change.
- Hex decode: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110; standard glyphs for the remaining values.

## Timing
- Reset values: an=4'b1111, seg=7'h7F, dp=1, frame_start=0, load_ready=1, index=0, state=DISPLAY, prescaler=0, active and shadow sets all zero (display dark), pending=0.
- All outputs are registered. an, seg and dp reflect a new index/state one cycle after the internal transition.
- Frame period is 4*(REFRESH_DIV+BLANK_CYCLES) cycles, or 4*REFRESH_DIV without blanking.
- Worst-case load-to-display latency is two frame periods plus 2 cycles.
- Asynchronous reset mid-frame or mid-load forces reset values immediately; any pending shadow contents are discarded.
- load_valid held high while load_ready=0 has no effect; data must be held by the source until accepted.

## Configuration
- SEG7_BLANK_EN defined: BLANK state is compiled in, with the inter-digit blanking described above (suppresses ghosting).
- SEG7_BLANK_EN undefined: BLANK state and BLANK_CYCLES are unused, and slots are back-to-back.

## Structure
- Package seg7_pkg holds:
  - digit index typedef (logic [1:0]);
  - state enum;
  - anode code constants;
  - blank constants (AN_OFF=4'b1111, SEG_OFF=7'h7F);
  - the 16-entry hex-to-segment table.
- One combinational sub-module, seg7_hex_to_seg: 4-bit nibble in, 7-bit active-low segment out.
- Everything else lives in seg7_scan_ctrl.

## Test plan
Benches use REFRESH_DIV=4, BLANK_CYCLES=2.
- Reset: assert rst_n=0 mid-slot -> same cycle an=1111, seg=7F, dp=1, load_ready=1. After release, no anode goes low until a load lands.
- Basic load: load_data=16'h3210, load_en=4'hF, load_dp=4'b0100 -> after the next boundary, the slot sequence is an=1110/seg=1000000, 1101/1111001, 1011/0100100 with dp=0, then 0111/0110000. Each slot is lit 4 cycles; frame_start pulses once per 24-cycle frame.
- Back-pressure: a second load during pending -> load_ready=0 and the second value is ignored until the boundary. load_ready rises the cycle after the boundary and the second load is then accepted.
- Boundary collision: a load accepted exactly on the wrap cycle -> the old data is shown for one more full frame.
- Enable mask: load_en=4'b0101 -> an never shows 1101 or 0111, and seg=7F during those slots.
- Blanking: with SEG7_BLANK_EN, 2 cycles of an=1111 appear between slots. Without it, there are zero such cycles and the frame is 16 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, anode codes, blanking constants and hex glyph table for the scan controller.
package seg7_pkg;
  typedef logic [1:0] digit_t;
  typedef enum logic {DISPLAY, BLANK} state_t;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_CODE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seg7_hex_to_seg.sv
// seg7_hex_to_seg: nibble to active-low {g,f,e,d,c,b,a} glyph.
module seg7_hex_to_seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit multiplexed 7-seg scanner with tear-free shadow loading.
// Define SEG7_BLANK_EN to insert BLANK_CYCLES of all-off between digit slots.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  input  logic [3:0]  load_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);
  localparam int MAXC = REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC);
  state_t state, state_n;
  digit_t idx;
  logic [CW-1:0] cnt;
  logic [15:0] act_data, sh_data;
  logic [3:0] act_dp, act_en, sh_dp, sh_en;
  logic pending, adv, chg, wrap, lit;
  logic [3:0] nib;
  logic [6:0] dec;
  assign load_ready = ~pending;
`ifdef SEG7_BLANK_EN
  always_comb begin
    state_n = state == DISPLAY ? (cnt == CW'(REFRESH_DIV - 1) ? BLANK : DISPLAY)
                               : (cnt == CW'(BLANK_CYCLES - 1) ? DISPLAY : BLANK);
    adv = state == BLANK && state_n == DISPLAY;
    chg = state_n != state;
  end
`else
  always_comb begin
    state_n = DISPLAY;
    adv = cnt == CW'(REFRESH_DIV - 1);
    chg = adv;
  end
`endif
  assign wrap = adv && idx == 2'd3;
  assign lit = state == DISPLAY && act_en[idx];
  assign nib = act_data[{idx, 2'b00} +: 4];
  seg7_hex_to_seg u_hex (.nibble(nib), .seg(dec));
  // Shadow copies into active only on the wrap so a frame never mixes old and new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DISPLAY;
      idx <= '0;
      cnt <= '0;
      pending <= 1'b0;
      act_data <= '0;
      act_dp <= '0;
      act_en <= '0;
      sh_data <= '0;
      sh_dp <= '0;
      sh_en <= '0;
      an <= AN_OFF;
      seg <= SEG_OFF;
      dp <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= chg ? '0 : cnt + 1'b1;
      if (adv) idx <= idx + 1'b1;
      if (wrap && pending) begin
        act_data <= sh_data;
        act_dp <= sh_dp;
        act_en <= sh_en;
        pending <= 1'b0;
      end else if (load_valid && load_ready) begin
        sh_data <= load_data;
        sh_dp <= load_dp;
        sh_en <= load_en;
        pending <= 1'b1;
      end
      an <= lit ? AN_CODE[idx] : AN_OFF;
      seg <= lit ? dec : SEG_OFF;
      dp <= lit ? ~act_dp[idx] : 1'b1;
      frame_start <= state == DISPLAY && idx == 2'd0 && cnt == '0;
    end
  end
endmodule
